id_ex_stage: RTL and testbench

- ID/EX pipeline register sitting directly upstream of the ALU.
- Captures decoded operands and control from decode, then drives ALU operands A/B and funct3/funct7 in EX.
- Applies EX/MEM and MEM/WB operand forwarding, and detects load-use hazards.
- Supports stall, flush, and bubble insertion.

---
 rtl/id_ex_stage_if.sv | 74 +++++++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Brief    : Decode-side, hazard/forwarding and EX-side signal bundle for
//            the ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [RA_W-1:0] id_rs1_addr;
    logic [RA_W-1:0] id_rs2_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic [RA_W-1:0] id_rd_addr;
    logic            id_use_imm;
    logic            id_use_pc;
    logic            id_uses_rs2;
    logic            id_force_add;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            stall;
    logic            flush;
    logic [RA_W-1:0] exm_rd;
    logic            exm_reg_write;
    logic [XLEN-1:0] exm_result;
    logic [RA_W-1:0] mw_rd;
    logic            mw_reg_write;
    logic [XLEN-1:0] mw_result;
    logic            ex_valid;
    logic [XLEN-1:0] ex_alu_a;
    logic [XLEN-1:0] ex_alu_b;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] ex_pc;
    logic [RA_W-1:0] ex_rd_addr;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            load_use_stall;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data,
               id_rs2_data, id_imm, id_funct3, id_funct7, id_rd_addr,
               id_use_imm, id_use_pc, id_uses_rs2, id_force_add,
               id_reg_write, id_mem_read, id_mem_write, stall, flush,
               exm_rd, exm_reg_write, exm_result, mw_rd, mw_reg_write,
               mw_result,
        input  ex_valid, ex_alu_a, ex_alu_b, ex_funct3, ex_funct7,
               ex_store_data, ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read,
               ex_mem_write, load_use_stall
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data,
               id_rs2_data, id_imm, id_funct3, id_funct7, id_rd_addr,
               id_use_imm, id_use_pc, id_uses_rs2, id_force_add,
               id_reg_write, id_mem_read, id_mem_write, stall, flush,
               exm_rd, exm_reg_write, exm_result, mw_rd, mw_reg_write,
               mw_result,
        output ex_valid, ex_alu_a, ex_alu_b, ex_funct3, ex_funct7,
               ex_store_data, ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read,
               ex_mem_write, load_use_stall
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with operand forwarding, funct
//            normalisation and load-use hazard detection.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  wire           clk,
    input  wire           rst_n,
    id_ex_stage_if.slave  bus
);
    localparam logic [2:0]      c_FUNCT3_SR  = 3'b101;
    localparam logic [RA_W-1:0] c_REG_ZERO   = '0;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [RA_W-1:0] r_rs1_addr;
    logic [RA_W-1:0] r_rs2_addr;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [RA_W-1:0] r_rd_addr;
    logic            r_use_imm;
    logic            r_use_pc;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;

    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [2:0]      w_funct3_n;
    logic [6:0]      w_funct7_n;
    logic            w_load_use;

    // EX/MEM takes priority over MEM/WB; x0 is never forwarded.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (bus.exm_reg_write && bus.exm_rd != c_REG_ZERO && bus.exm_rd == r_rs1_addr)
            w_fwd_rs1 = bus.exm_result;
        else if (bus.mw_reg_write && bus.mw_rd != c_REG_ZERO && bus.mw_rd == r_rs1_addr)
            w_fwd_rs1 = bus.mw_result;
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (bus.exm_reg_write && bus.exm_rd != c_REG_ZERO && bus.exm_rd == r_rs2_addr)
            w_fwd_rs2 = bus.exm_result;
        else if (bus.mw_reg_write && bus.mw_rd != c_REG_ZERO && bus.mw_rd == r_rs2_addr)
            w_fwd_rs2 = bus.mw_result;
    end

    // Immediate forms only keep funct7 for shifts, so ADDI/SLTI never look
    // like subtract and SRAI keeps its arithmetic bit.
    always_comb begin
        w_funct3_n = bus.id_funct3;
        w_funct7_n = bus.id_funct7;
        if (bus.id_force_add) begin
            w_funct3_n = 3'b000;
            w_funct7_n = 7'b0000000;
        end else if (bus.id_use_imm && bus.id_funct3 != c_FUNCT3_SR) begin
            w_funct7_n = 7'b0000000;
        end
    end

    assign w_load_use = !bus.flush && r_valid && r_mem_read &&
                        r_rd_addr != c_REG_ZERO && bus.id_valid &&
                        (bus.id_rs1_addr == r_rd_addr ||
                         (bus.id_uses_rs2 && bus.id_rs2_addr == r_rd_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_funct3    <= '0;
            r_funct7    <= '0;
            r_rd_addr   <= '0;
            r_use_imm   <= 1'b0;
            r_use_pc    <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (bus.flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (bus.stall) begin
            // Snapshot forwarded operands so they survive the producer retiring.
            if (r_valid) begin
                r_rs1_data <= w_fwd_rs1;
                r_rs2_data <= w_fwd_rs2;
            end
        end else if (w_load_use) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_valid     <= bus.id_valid;
            r_pc        <= bus.id_pc;
            r_rs1_addr  <= bus.id_rs1_addr;
            r_rs2_addr  <= bus.id_rs2_addr;
            r_rs1_data  <= bus.id_rs1_data;
            r_rs2_data  <= bus.id_rs2_data;
            r_imm       <= bus.id_imm;
            r_funct3    <= w_funct3_n;
            r_funct7    <= w_funct7_n;
            r_rd_addr   <= bus.id_rd_addr;
            r_use_imm   <= bus.id_use_imm;
            r_use_pc    <= bus.id_use_pc;
            r_reg_write <= bus.id_reg_write;
            r_mem_read  <= bus.id_mem_read;
            r_mem_write <= bus.id_mem_write;
        end
    end

    assign bus.ex_valid       = r_valid;
    assign bus.ex_alu_a       = r_use_pc  ? r_pc  : w_fwd_rs1;
    assign bus.ex_alu_b       = r_use_imm ? r_imm : w_fwd_rs2;
    assign bus.ex_funct3      = r_funct3;
    assign bus.ex_funct7      = r_funct7;
    assign bus.ex_store_data  = w_fwd_rs2;
    assign bus.ex_pc          = r_pc;
    assign bus.ex_rd_addr     = r_rd_addr;
    assign bus.ex_reg_write   = r_reg_write & r_valid;
    assign bus.ex_mem_read    = r_mem_read  & r_valid;
    assign bus.ex_mem_write   = r_mem_write & r_valid;
    assign bus.load_use_stall = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed self-checking bench for id_ex_stage.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;
    localparam int c_XLEN = 32;
    localparam int c_RA_W = 5;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    id_ex_stage_if #(.XLEN(c_XLEN), .RA_W(c_RA_W)) bus ();

    id_ex_stage #(.XLEN(c_XLEN), .RA_W(c_RA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1_addr = '0; bus.id_rs2_addr = '0;
        bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
        bus.id_funct3 = '0; bus.id_funct7 = '0; bus.id_rd_addr = '0;
        bus.id_use_imm = 0; bus.id_use_pc = 0; bus.id_uses_rs2 = 0; bus.id_force_add = 0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
        bus.stall = 0; bus.flush = 0;
        bus.exm_rd = '0; bus.exm_reg_write = 0; bus.exm_result = '0;
        bus.mw_rd = '0; bus.mw_reg_write = 0; bus.mw_result = '0;
    endtask

    // Load one decoded instruction onto the ID inputs.
    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] rd, input logic use_imm,
                          input logic uses_rs2, input logic force_add, input logic rw,
                          input logic mr, input logic mw);
        bus.id_valid = 1; bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
        bus.id_funct3 = f3; bus.id_funct7 = f7; bus.id_rd_addr = rd;
        bus.id_use_imm = use_imm; bus.id_uses_rs2 = uses_rs2; bus.id_force_add = force_add;
        bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_all();
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", 32'(bus.ex_valid), 32'h0);
        check_eq("rst_alu_a", bus.ex_alu_a, 32'h0);
        check_eq("rst_lus", 32'(bus.load_use_stall), 32'h0);
        rst_n = 1'b1;

        // Reset mid-operation, asynchronous
        set_id(5'd2, 5'd3, 32'h1234, 32'h5678, 32'h0, 3'b000, 7'h00, 5'd5, 0, 1, 0, 1, 0, 0);
        bus.id_pc = 32'h100;
        tick();
        check_eq("cap_valid", 32'(bus.ex_valid), 32'h1);
        check_eq("cap_alu_a", bus.ex_alu_a, 32'h1234);
        check_eq("cap_rw", 32'(bus.ex_reg_write), 32'h1);
        check_eq("cap_pc", bus.ex_pc, 32'h100);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(bus.ex_valid), 32'h0);
        check_eq("arst_alu_a", bus.ex_alu_a, 32'h0);
        check_eq("arst_rw", 32'(bus.ex_reg_write), 32'h0);
        check_eq("arst_pc", bus.ex_pc, 32'h0);
        tick();
        rst_n = 1'b1;

        // SUB x6,x5,x1 with forwarding
        set_id(5'd5, 5'd1, 32'h111, 32'h222, 32'h0, 3'b000, 7'b0100000, 5'd6, 0, 1, 0, 1, 0, 0);
        tick();
        bus.id_valid = 0;
        bus.exm_rd = 5'd5; bus.exm_reg_write = 1; bus.exm_result = 32'h10;
        bus.mw_rd = 5'd5; bus.mw_reg_write = 1; bus.mw_result = 32'h20;
        #1;
        check_eq("fwd_exm_a", bus.ex_alu_a, 32'h10);
        check_eq("fwd_b_raw", bus.ex_alu_b, 32'h222);
        check_eq("sub_f7", 32'(bus.ex_funct7), 32'h20);
        bus.exm_rd = 5'd3;
        #1;
        check_eq("fwd_mw_a", bus.ex_alu_a, 32'h20);
        bus.exm_rd = 5'd0; bus.mw_rd = 5'd0;
        #1;
        check_eq("fwd_x0_a", bus.ex_alu_a, 32'h111);
        bus.exm_rd = 5'd1;
        #1;
        check_eq("fwd_exm_b", bus.ex_alu_b, 32'h10);
        check_eq("fwd_exm_sd", bus.ex_store_data, 32'h10);
        bus.exm_rd = '0; bus.exm_reg_write = 0; bus.mw_reg_write = 0;

        // ADDI x3,x2,-1 with junk funct7
        set_id(5'd2, 5'd31, 32'h5, 32'h0, 32'hFFFF_FFFF, 3'b000, 7'h7F, 5'd3, 1, 0, 0, 1, 0, 0);
        tick();
        check_eq("addi_f7", 32'(bus.ex_funct7), 32'h0);
        check_eq("addi_b", bus.ex_alu_b, 32'hFFFF_FFFF);
        check_eq("addi_a", bus.ex_alu_a, 32'h5);
        // SRAI keeps funct7[5]
        set_id(5'd2, 5'd4, 32'h80, 32'h0, 32'h404, 3'b101, 7'b0100000, 5'd3, 1, 0, 0, 1, 0, 0);
        tick();
        check_eq("srai_f7", 32'(bus.ex_funct7), 32'h20);
        check_eq("srai_f3", 32'(bus.ex_funct3), 32'h5);
        // SW x9,8(x2)
        set_id(5'd2, 5'd9, 32'h1000, 32'hCAFE, 32'h8, 3'b010, 7'h05, 5'd0, 1, 1, 1, 0, 0, 1);
        tick();
        check_eq("sw_f3", 32'(bus.ex_funct3), 32'h0);
        check_eq("sw_f7", 32'(bus.ex_funct7), 32'h0);
        check_eq("sw_mw", 32'(bus.ex_mem_write), 32'h1);
        check_eq("sw_sd", bus.ex_store_data, 32'hCAFE);

        // LW x7 then ADD x8,x7,x0
        set_id(5'd2, 5'd0, 32'h2000, 32'h0, 32'h4, 3'b010, 7'h0, 5'd7, 1, 0, 1, 1, 1, 0);
        tick();
        check_eq("lw_mr", 32'(bus.ex_mem_read), 32'h1);
        set_id(5'd7, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 7'h0, 5'd8, 0, 1, 0, 1, 0, 0);
        #1;
        check_eq("lus_hit", 32'(bus.load_use_stall), 32'h1);
        tick();
        check_eq("bubble_valid", 32'(bus.ex_valid), 32'h0);
        check_eq("bubble_rw", 32'(bus.ex_reg_write), 32'h0);
        check_eq("bubble_lus", 32'(bus.load_use_stall), 32'h0);
        // LW x7 then ADDI x8,x2,1 with stale rs2=7
        set_id(5'd2, 5'd0, 32'h2000, 32'h0, 32'h4, 3'b010, 7'h0, 5'd7, 1, 0, 1, 1, 1, 0);
        tick();
        set_id(5'd2, 5'd7, 32'h0, 32'h0, 32'h1, 3'b000, 7'h0, 5'd8, 1, 0, 0, 1, 0, 0);
        #1;
        check_eq("lus_no_rs2", 32'(bus.load_use_stall), 32'h0);
        bus.id_rs1_addr = 5'd7;
        #1;
        check_eq("lus_rs1", 32'(bus.load_use_stall), 32'h1);
        bus.flush = 1;
        #1;
        check_eq("lus_flush", 32'(bus.load_use_stall), 32'h0);
        bus.stall = 1;
        tick();
        check_eq("flush_stall_v", 32'(bus.ex_valid), 32'h0);
        check_eq("flush_stall_mr", 32'(bus.ex_mem_read), 32'h0);
        bus.flush = 0; bus.stall = 0;

        // Stall keeps forwarded MEM/WB value after it drains
        set_id(5'd9, 5'd10, 32'h1, 32'h2, 32'h0, 3'b000, 7'h0, 5'd11, 0, 1, 0, 1, 0, 0);
        bus.id_pc = 32'h300;
        tick();
        bus.stall = 1;
        bus.mw_rd = 5'd9; bus.mw_reg_write = 1; bus.mw_result = 32'hABCD;
        bus.id_pc = 32'h304; bus.id_rs1_data = 32'h77;
        #1;
        check_eq("stall_fwd_a", bus.ex_alu_a, 32'hABCD);
        tick();
        check_eq("stall_hold_pc", bus.ex_pc, 32'h300);
        check_eq("stall_hold_v", 32'(bus.ex_valid), 32'h1);
        bus.stall = 0; bus.mw_reg_write = 0;
        #1;
        check_eq("stall_kept_a", bus.ex_alu_a, 32'hABCD);
        check_eq("stall_kept_b", bus.ex_alu_b, 32'h2);
        tick();
        check_eq("resume_pc", bus.ex_pc, 32'h304);
        check_eq("resume_a", bus.ex_alu_a, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
